inst_pipe_regs: RTL and testbench

Instruction/PC pipeline register bank between fetch and the execute/memory/writeback stages. It captures the fetched instruction and PC, then advances them through the X, M and W stages. It applies the stall and flush decisions produced by the pipelined controller, inserting NOP bubbles where required. It drives the inst_x/inst_m/inst_w buses the controller decodes, plus the matching PCs and valid bits.

---
 rtl/inst_pipe_regs.sv | 147 ++++++++++++++
 tb/tb_inst_pipe_regs.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/inst_pipe_regs.sv
// inst_pipe_regs: instruction/PC pipeline registers for the X, M and W stages.
//
// The fetched instruction and its PC advance F -> X -> M -> W. The controller's
// stall and flush decisions are applied here, and NOP bubbles are inserted where
// the pipeline needs them.
//
// Ports:
//   clk, rst                  clock; synchronous active-high reset
//   inst_f, pc_f, fetch_valid fetched instruction, its PC, and its valid bit
//   stall, flush              load-use stall and taken branch/jump from the controller
//   fetch_hold                tells the PC logic to re-present the same fetch
//   inst_x/m/w, pc_x/m/w      per-stage instruction and PC
//   valid_x/m/w               the stage holds a real (non-bubble) instruction
//   retire                    an instruction completes writeback this cycle
//
// Optional build macro PIPE_PERF_CNT_EN adds the performance counter outputs
// cycle_cnt, instret_cnt, stall_cnt and flush_cnt.
module inst_pipe_regs #(
   parameter int unsigned        AWIDTH = 32,
   parameter int unsigned        DWIDTH = 32,
   parameter logic [DWIDTH-1:0]  NOP    = 32'h00000013
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DWIDTH-1:0] inst_f,
   input  logic [AWIDTH-1:0] pc_f,
   input  logic              fetch_valid,
   input  logic              stall,
   input  logic              flush,
   output logic              fetch_hold,
   output logic [DWIDTH-1:0] inst_x,
   output logic [DWIDTH-1:0] inst_m,
   output logic [DWIDTH-1:0] inst_w,
   output logic [AWIDTH-1:0] pc_x,
   output logic [AWIDTH-1:0] pc_m,
   output logic [AWIDTH-1:0] pc_w,
   output logic              valid_x,
   output logic              valid_m,
   output logic              valid_w,
`ifdef PIPE_PERF_CNT_EN
   output logic [63:0]       cycle_cnt,
   output logic [63:0]       instret_cnt,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       flush_cnt,
`endif
   output logic              retire
);

   logic [DWIDTH-1:0] inst_x_q, inst_x_d, inst_m_q, inst_m_d, inst_w_q, inst_w_d;
   logic [AWIDTH-1:0] pc_x_q, pc_x_d, pc_m_q, pc_m_d, pc_w_q, pc_w_d;
   logic              valid_x_q, valid_x_d, valid_m_q, valid_m_d, valid_w_q, valid_w_d;

   always_comb begin
      inst_x_d  = inst_x_q;
      pc_x_d    = pc_x_q;
      valid_x_d = valid_x_q;
      // W always takes M, even while stalled: the load in M must drain.
      inst_w_d  = inst_m_q;
      pc_w_d    = pc_m_q;
      valid_w_d = valid_m_q;
      if (stall) begin
         // Stall beats flush: the branch in X waits on the load ahead of it.
         inst_m_d  = NOP;
         pc_m_d    = pc_x_q;
         valid_m_d = 1'b0;
      end else begin
         inst_m_d  = inst_x_q;
         pc_m_d    = pc_x_q;
         valid_m_d = valid_x_q;
         // Bubbles and squashed fetches keep the fetch PC for debug.
         pc_x_d    = pc_f;
         if (fetch_valid && !flush) begin
            inst_x_d  = inst_f;
            valid_x_d = 1'b1;
         end else begin
            inst_x_d  = NOP;
            valid_x_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         inst_x_q  <= NOP;
         inst_m_q  <= NOP;
         inst_w_q  <= NOP;
         pc_x_q    <= '0;
         pc_m_q    <= '0;
         pc_w_q    <= '0;
         valid_x_q <= 1'b0;
         valid_m_q <= 1'b0;
         valid_w_q <= 1'b0;
      end else begin
         inst_x_q  <= inst_x_d;
         inst_m_q  <= inst_m_d;
         inst_w_q  <= inst_w_d;
         pc_x_q    <= pc_x_d;
         pc_m_q    <= pc_m_d;
         pc_w_q    <= pc_w_d;
         valid_x_q <= valid_x_d;
         valid_m_q <= valid_m_d;
         valid_w_q <= valid_w_d;
      end
   end

   always_comb begin
      fetch_hold = stall & ~rst;
      inst_x     = inst_x_q;
      inst_m     = inst_m_q;
      inst_w     = inst_w_q;
      pc_x       = pc_x_q;
      pc_m       = pc_m_q;
      pc_w       = pc_w_q;
      valid_x    = valid_x_q;
      valid_m    = valid_m_q;
      valid_w    = valid_w_q;
      retire     = valid_w_q;
   end

`ifdef PIPE_PERF_CNT_EN
   logic [63:0] cycle_cnt_q, instret_cnt_q;
   logic [31:0] stall_cnt_q, flush_cnt_q;

   // All counters wrap naturally on overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_cnt_q   <= '0;
         instret_cnt_q <= '0;
         stall_cnt_q   <= '0;
         flush_cnt_q   <= '0;
      end else begin
         cycle_cnt_q <= cycle_cnt_q + 64'd1;
         if (valid_w_q)       instret_cnt_q <= instret_cnt_q + 64'd1;
         if (stall)           stall_cnt_q   <= stall_cnt_q + 32'd1;
         if (flush && !stall) flush_cnt_q   <= flush_cnt_q + 32'd1;
      end
   end

   always_comb begin
      cycle_cnt   = cycle_cnt_q;
      instret_cnt = instret_cnt_q;
      stall_cnt   = stall_cnt_q;
      flush_cnt   = flush_cnt_q;
   end
`endif

endmodule

// File: tb/tb_inst_pipe_regs.sv
module tb_inst_pipe_regs;

   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk = 1'b0;
   logic        rst, fetch_valid, stall, flush;
   logic [31:0] inst_f, pc_f;
   logic        fetch_hold, valid_x, valid_m, valid_w, retire;
   logic [31:0] inst_x, inst_m, inst_w, pc_x, pc_m, pc_w;
`ifdef PIPE_PERF_CNT_EN
   logic [63:0] cycle_cnt, instret_cnt;
   logic [31:0] stall_cnt, flush_cnt;
`endif

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   inst_pipe_regs dut (
      .clk         (clk),
      .rst         (rst),
      .inst_f      (inst_f),
      .pc_f        (pc_f),
      .fetch_valid (fetch_valid),
      .stall       (stall),
      .flush       (flush),
      .fetch_hold  (fetch_hold),
      .inst_x      (inst_x),
      .inst_m      (inst_m),
      .inst_w      (inst_w),
      .pc_x        (pc_x),
      .pc_m        (pc_m),
      .pc_w        (pc_w),
      .valid_x     (valid_x),
      .valid_m     (valid_m),
      .valid_w     (valid_w),
`ifdef PIPE_PERF_CNT_EN
      .cycle_cnt   (cycle_cnt),
      .instret_cnt (instret_cnt),
      .stall_cnt   (stall_cnt),
      .flush_cnt   (flush_cnt),
`endif
      .retire      (retire)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Inputs set before a step are sampled at its edge; outputs are read 1 ns later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [31:0] i, input logic [31:0] p);
      inst_f      = i;
      pc_f        = p;
      fetch_valid = 1'b1;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      fetch(32'h00500093, 32'h0);
      step();
      stall = 1'b1;
      #1 chk("hold_in_rst", {63'd0, fetch_hold}, 64'd0);
      step();
      rst = 1'b0; stall = 1'b0;
      #1;
      chk("rst_inst_x", inst_x, NOP);
      chk("rst_inst_m", inst_m, NOP);
      chk("rst_inst_w", inst_w, NOP);
      chk("rst_valid", {61'd0, valid_x, valid_m, valid_w}, 64'd0);
      chk("rst_retire", {63'd0, retire}, 64'd0);
      chk("rst_pc", {pc_x, pc_m ^ pc_w}, 64'd0);

      // Straight-line code
      fetch(32'h00100093, 32'h0); step();                             // S1
      chk("s1_inst_x", inst_x, 32'h00100093);
      chk("s1_valid_x", {63'd0, valid_x}, 64'd1);
      fetch(32'h00200113, 32'h4); step();                             // S2
      chk("s2_inst_m", inst_m, 32'h00100093);
      chk("s2_inst_x", inst_x, 32'h00200113);
      fetch(32'h00308193, 32'h8); step();                             // S3
      chk("s3_inst_w", inst_w, 32'h00100093);
      chk("s3_retire", {63'd0, retire}, 64'd1);
      chk("s3_pc_x", pc_x, 32'h8);

      // Two fetch bubbles
      fetch_valid = 1'b0; step();                                     // S4
      chk("s4_retire", {63'd0, retire}, 64'd1);
      chk("s4_bubble_x", {valid_x, inst_x}, {1'b0, NOP});
      step();                                                         // S5
      chk("s5_inst_w", inst_w, 32'h00308193);
      chk("s5_bubble_m", {valid_m, inst_m}, {1'b0, NOP});
      fetch(32'h0002A283, 32'hC); step();                             // S6: lw
      chk("s6_no_retire", {63'd0, retire}, 64'd0);
      fetch(32'h00528333, 32'h10); step();                            // S7: add
      chk("s7_no_retire", {63'd0, retire}, 64'd0);
      chk("s7_inst_m", inst_m, 32'h0002A283);

      // Load-use stall
      fetch(32'h00000463, 32'h14); stall = 1'b1;
      #1 chk("hold_on_stall", {63'd0, fetch_hold}, 64'd1);
      step();                                                         // S8
      chk("s8_x_held", {valid_x, pc_x, inst_x}, {1'b1, 32'h10, 32'h00528333});
      chk("s8_m_bubble", {valid_m, pc_m, inst_m}, {1'b0, 32'h10, NOP});
      chk("s8_w_lw", inst_w, 32'h0002A283);
      stall = 1'b0; step();                                           // S9
      chk("s9_add_in_m", {valid_m, inst_m}, {1'b1, 32'h00528333});
      chk("s9_beq_in_x", {pc_x, inst_x}, {32'h14, 32'h00000463});

      // Taken branch, then a second flush
      fetch(32'hDEADBEEF, 32'h18); flush = 1'b1; step();              // S10
      chk("s10_beq_m", {valid_m, pc_m, inst_m}, {1'b1, 32'h14, 32'h00000463});
      chk("s10_squash_x", {valid_x, inst_x}, {1'b0, NOP});
      fetch(32'hDEADBEEF, 32'h1C); step();                            // S11
      chk("s11_squash_x", {valid_x, inst_x}, {1'b0, NOP});
      chk("s11_beq_w", {valid_w, inst_w}, {1'b1, 32'h00000463});

      // Stall and flush together, then flush alone
      flush = 1'b0; fetch(32'h00000863, 32'h40); step();              // S12
      fetch(32'hDEADBEEF, 32'h44); stall = 1'b1; flush = 1'b1; step();// S13
      chk("s13_x_held", {valid_x, pc_x, inst_x}, {1'b1, 32'h40, 32'h00000863});
      chk("s13_m_bubble", {valid_m, inst_m}, {1'b0, NOP});
      stall = 1'b0; step();                                           // S14
      chk("s14_br_m", {valid_m, pc_m, inst_m}, {1'b1, 32'h40, 32'h00000863});
      chk("s14_squash_x", {valid_x, inst_x}, {1'b0, NOP});

      // Back-to-back stalls
      flush = 1'b0; fetch(32'h00100093, 32'h44); step();              // S15
      chk("s15_retire", {63'd0, retire}, 64'd1);
      stall = 1'b1; step(); step();                                   // S16, S17
      chk("s17_x_held", {valid_x, inst_x}, {1'b1, 32'h00100093});
      chk("s17_m_bubble", {valid_m, inst_m}, {1'b0, NOP});
      chk("s17_w_bubble", {valid_w, inst_w}, {1'b0, NOP});
`ifdef PIPE_PERF_CNT_EN
      chk("cnt_cycle", cycle_cnt, 64'd17);
      chk("cnt_instret", instret_cnt, 64'd7);
      chk("cnt_stall", {32'd0, stall_cnt}, 64'd4);
      chk("cnt_flush", {32'd0, flush_cnt}, 64'd3);
`endif

      // Reset mid-stream overrides the stall
      rst = 1'b1; step();                                             // S18
      chk("mid_rst_x", {valid_x, inst_x}, {1'b0, NOP});
      chk("mid_rst_pc_x", pc_x, 32'h0);
      rst = 1'b0; stall = 1'b0; fetch(32'h00400213, 32'h80); step();  // S19
      chk("post_rst_x", {valid_x, pc_x, inst_x}, {1'b1, 32'h80, 32'h00400213});
      chk("post_rst_m", {valid_m, inst_m}, {1'b0, NOP});
`ifdef PIPE_PERF_CNT_EN
      chk("post_rst_cycle", cycle_cnt, 64'd1);
      chk("post_rst_instret", instret_cnt, 64'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
